obstacle_scheduler: RTL and testbench



---
 rtl/obstacle_scheduler_pkg.sv | 15 +
 rtl/obstacle_scheduler_if.sv | 28 ++
 rtl/obstacle_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_obstacle_scheduler.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/obstacle_scheduler_pkg.sv
// Shared types for the obstacle scheduler: slot count, position width and
// the packed obstacle record seen by the collision checker and renderer.
`timescale 1ns/1ps
package obstacle_scheduler_pkg;

  localparam int NUM_SLOTS = 10;
  localparam int POS_W     = 10;

  typedef struct packed {
    logic             active;
    logic [1:0]       lane;
    logic [POS_W-1:0] position;
  } obstacle_t;

endpackage

// File: rtl/obstacle_scheduler_if.sv
// Game-side interface of the obstacle scheduler.
// The game controller (master) drives start, game_tick, died and speed.
// The scheduler (slave) returns the obstacle table plus its status pulses.
`timescale 1ns/1ps
interface obstacle_scheduler_if;
  import obstacle_scheduler_pkg::*;

  logic                      start;
  logic                      game_tick;
  logic                      died;
  logic [3:0]                speed;
  obstacle_t [NUM_SLOTS-1:0] obstacles;
  logic [15:0]               passed_count;
  logic                      busy;
  logic                      spawn_dropped;
  logic                      tick_overrun;

  modport master (
    output start, game_tick, died, speed,
    input  obstacles, passed_count, busy, spawn_dropped, tick_overrun
  );

  modport slave (
    input  start, game_tick, died, speed,
    output obstacles, passed_count, busy, spawn_dropped, tick_overrun
  );

endinterface

// File: rtl/obstacle_scheduler.sv
// Obstacle scheduler: owns the 10-slot obstacle table. Each accepted game
// tick sweeps one slot per cycle (advance or retire), then spends one cycle
// deciding whether to spawn a new obstacle at the far edge.
// Optional build macro: OBSTACLE_SCHEDULER_LANE_GUARD_EN -- when defined,
// a newly spawned obstacle never reuses the lane of the previous spawn.
`timescale 1ns/1ps
module obstacle_scheduler
  import obstacle_scheduler_pkg::*;
#(
  parameter int          SPAWN_POSITION  = 640,
  parameter int          SPAWN_MIN_TICKS = 4,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input logic           system_clock_in,
  input logic           reset_n,
  obstacle_scheduler_if.slave bus
);

  localparam int TIMER_W = 8;
  localparam int IDX_W   = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLOTS - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SWEEP,
    SPAWN
  } state_t;

  state_t                    state;
  obstacle_t [NUM_SLOTS-1:0] slots;
  logic [15:0]               passed_count;
  logic [15:0]               lfsr;
  logic [TIMER_W-1:0]        spawn_timer;
  logic [IDX_W-1:0]          index;
  logic                      busy;
  logic                      spawn_dropped;
  logic                      tick_overrun;

  logic                      lfsr_feedback;
  logic                      free_found;
  logic [IDX_W-1:0]          free_idx;
  logic [1:0]                raw_lane;
  logic [1:0]                spawn_lane;
  logic [TIMER_W-1:0]        reload_value;
  logic [POS_W-1:0]          step;
  obstacle_t                 cur_slot;
  obstacle_t                 spawn_slot;

`ifdef OBSTACLE_SCHEDULER_LANE_GUARD_EN
  logic [1:0]                last_lane;
`endif

  // Fibonacci taps 16,14,13,11 expressed on a zero-based register.
  assign lfsr_feedback = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  // Lane 3 does not exist on screen, so the LFSR's fourth code folds onto lane 1.
  assign raw_lane = (lfsr[5:4] == 2'd3) ? 2'd1 : lfsr[5:4];

`ifdef OBSTACLE_SCHEDULER_LANE_GUARD_EN
  // Step to the next lane (mod 3) when the draw repeats the previous spawn.
  assign spawn_lane = (raw_lane != last_lane) ? raw_lane :
                      (raw_lane == 2'd2)      ? 2'd0     : raw_lane + 2'd1;
`else
  assign spawn_lane = raw_lane;
`endif

  assign reload_value = TIMER_W'(SPAWN_MIN_TICKS) + TIMER_W'(lfsr[3:0]);
  assign step         = POS_W'(bus.speed);
  assign cur_slot     = slots[index];

  // Record written into the chosen free slot when a spawn succeeds.
  always_comb begin
    spawn_slot          = '0;
    spawn_slot.active   = 1'b1;
    spawn_slot.lane     = spawn_lane;
    spawn_slot.position = POS_W'(SPAWN_POSITION);
  end

  // Priority search for the lowest-index inactive slot; the table it sees is
  // already swept, so a slot retired on this tick is immediately reusable.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!slots[i].active) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  // Free-running pseudo-random source; start deliberately does not reseed it.
  always_ff @(posedge system_clock_in) begin
    if (!reset_n) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[14:0], lfsr_feedback};
    end
  end

  // Scheduler FSM: start re-initialises from any state; WAIT accepts ticks,
  // SWEEP walks slots 0..9, SPAWN runs the spawn timer and places obstacles.
  always_ff @(posedge system_clock_in) begin
    if (!reset_n) begin
      state         <= IDLE;
      slots         <= '0;
      passed_count  <= '0;
      spawn_timer   <= '0;
      index         <= '0;
      busy          <= 1'b0;
      spawn_dropped <= 1'b0;
      tick_overrun  <= 1'b0;
`ifdef OBSTACLE_SCHEDULER_LANE_GUARD_EN
      last_lane     <= 2'd0;
`endif
    end else begin
      spawn_dropped <= 1'b0;
      tick_overrun  <= 1'b0;
      if (bus.start) begin
        state        <= WAIT;
        slots        <= '0;
        passed_count <= '0;
        spawn_timer  <= TIMER_W'(SPAWN_MIN_TICKS);
        index        <= '0;
        busy         <= 1'b0;
`ifdef OBSTACLE_SCHEDULER_LANE_GUARD_EN
        last_lane    <= 2'd0;
`endif
      end else begin
        tick_overrun <= bus.game_tick && busy;
        case (state)
          WAIT: begin
            if (bus.game_tick && !bus.died) begin
              index <= '0;
              state <= SWEEP;
              busy  <= 1'b1;
            end
          end
          SWEEP: begin
            if (cur_slot.active) begin
              if (cur_slot.position < step) begin
                slots[index].active <= 1'b0;
                if (passed_count != 16'hFFFF) begin
                  passed_count <= passed_count + 16'd1;
                end
              end else begin
                slots[index].position <= cur_slot.position - step;
              end
            end
            if (index == LAST_IDX) begin
              state <= SPAWN;
            end else begin
              index <= index + IDX_W'(1);
            end
          end
          SPAWN: begin
            if (spawn_timer != '0) begin
              spawn_timer <= spawn_timer - TIMER_W'(1);
            end else begin
              spawn_timer <= reload_value;
              if (free_found) begin
                slots[free_idx] <= spawn_slot;
`ifdef OBSTACLE_SCHEDULER_LANE_GUARD_EN
                last_lane       <= spawn_lane;
`endif
              end else begin
                spawn_dropped <= 1'b1;
              end
            end
            state <= WAIT;
            busy  <= 1'b0;
          end
          default: begin
            state <= state;
          end
        endcase
      end
    end
  end

  assign bus.obstacles     = slots;
  assign bus.passed_count  = passed_count;
  assign bus.busy          = busy;
  assign bus.spawn_dropped = spawn_dropped;
  assign bus.tick_overrun  = tick_overrun;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Scoreboard bench for obstacle_scheduler. Each issued tick queues the
// table state expected once that sweep completes; a monitor compares when
// busy falls. Static states (reset, after start, frozen) are checked inline.
`timescale 1ns/1ps
module tb_obstacle_scheduler;
  import obstacle_scheduler_pkg::*;

  localparam int SPAWN_POS = 640;

  typedef struct {
    string name;
    int    passed;
    int    s0_mode;   // 0 inactive, 1 active at s0_pos, 2 any, 3 inactive or fresh spawn
    int    s0_pos;
    int    drop;      // -1 = don't care
    int    act;       // -1 = don't care
    int    all_pos;   // -1 = don't care, else every active slot sits here
    int    overruns;  // cumulative tick_overrun pulses expected so far
  } exp_t;

  logic system_clock_in = 1'b0;
  logic reset_n = 1'b0;

  obstacle_scheduler_if bus();

  obstacle_scheduler dut (
    .system_clock_in (system_clock_in),
    .reset_n         (reset_n),
    .bus             (bus)
  );

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   overrun_seen = 0;
  int   drop_seen = 0;
  int   busy_cycles = 0;
  int   seen_active = 0;
  int   guard_last = 0;

  always #5 system_clock_in = ~system_clock_in;

  function automatic void compare(string name, int actual, int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, required);
    end
  endfunction

  function automatic int count_active();
    int n = 0;
    for (int i = 0; i < NUM_SLOTS; i++) if (bus.obstacles[i].active) n++;
    return n;
  endfunction

  function automatic exp_t mk(string name, int passed, int s0_mode, int s0_pos,
                              int drop, int act, int all_pos, int overruns);
    exp_t e;
    e.name = name; e.passed = passed; e.s0_mode = s0_mode; e.s0_pos = s0_pos;
    e.drop = drop; e.act = act; e.all_pos = all_pos; e.overruns = overruns;
    return e;
  endfunction

  // Pulse game_tick once; optionally queue the expected post-sweep state.
  // Returns gap negedges after the pulse ends, so the sweep has settled.
  task automatic applyStimulus(input exp_t e, input bit expect_sweep, input int gap);
    if (expect_sweep) exp_q.push_back(e);
    @(negedge system_clock_in) bus.game_tick = 1'b1;
    @(negedge system_clock_in) bus.game_tick = 1'b0;
    repeat (gap - 1) @(negedge system_clock_in);
  endtask

  task automatic doStart();
    @(negedge system_clock_in) bus.start = 1'b1;
    guard_last = 0;
    @(negedge system_clock_in) bus.start = 1'b0;
    @(negedge system_clock_in);
  endtask

  // Snapshot check of an idle (not busy) scheduler.
  task automatic checkOutput(string name, int passed, int act, int s0_active, int s0_pos);
    compare($sformatf("%s passed_count", name), int'(bus.passed_count), passed);
    compare($sformatf("%s active_slots", name), count_active(), act);
    compare($sformatf("%s busy", name), int'(bus.busy), 0);
    compare($sformatf("%s slot0_active", name), int'(bus.obstacles[0].active), s0_active);
    if (s0_pos >= 0)
      compare($sformatf("%s slot0_position", name), int'(bus.obstacles[0].position), s0_pos);
  endtask

  // Monitor: counts pulses and compares the queued expectation at each busy fall.
  initial begin : monitor
    logic     prev_busy;
    logic     prev_drop;
    logic [NUM_SLOTS-1:0] prev_act;
    exp_t     e;
    int       bad;
    prev_busy = 1'b0;
    prev_drop = 1'b0;
    prev_act  = '0;
    forever begin
      @(negedge system_clock_in);
      if (bus.tick_overrun) overrun_seen++;
      if (bus.spawn_dropped) begin
        drop_seen++;
        if (prev_drop) compare("spawn_dropped_width", 2, 1);
      end
      if (bus.busy) busy_cycles++;
      if (bus.busy && !prev_busy) compare("sweep_was_expected", int'(exp_q.size() > 0), 1);
      if (!bus.busy && prev_busy && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        seen_active = count_active();
        compare($sformatf("%s passed_count", e.name), int'(bus.passed_count), e.passed);
        case (e.s0_mode)
          0: compare($sformatf("%s slot0_active", e.name), int'(bus.obstacles[0].active), 0);
          1: begin
            compare($sformatf("%s slot0_active", e.name), int'(bus.obstacles[0].active), 1);
            compare($sformatf("%s slot0_position", e.name), int'(bus.obstacles[0].position), e.s0_pos);
          end
          3: compare($sformatf("%s slot0_retired_or_fresh", e.name),
                     int'(!bus.obstacles[0].active || bus.obstacles[0].position == 10'(SPAWN_POS)), 1);
          default: ;
        endcase
        if (e.drop >= 0)
          compare($sformatf("%s spawn_dropped", e.name), int'(bus.spawn_dropped), e.drop);
        if (e.act >= 0)
          compare($sformatf("%s active_slots", e.name), seen_active, e.act);
        if (e.all_pos >= 0) begin
          bad = 0;
          for (int i = 0; i < NUM_SLOTS; i++)
            if (bus.obstacles[i].active && int'(bus.obstacles[i].position) != e.all_pos) bad++;
          compare($sformatf("%s moved_slots", e.name), bad, 0);
        end
        compare($sformatf("%s tick_overrun_count", e.name), overrun_seen, e.overruns);
        bad = 0;
        for (int i = 0; i < NUM_SLOTS; i++) if (bus.obstacles[i].lane == 2'd3) bad++;
        compare($sformatf("%s lane3_slots", e.name), bad, 0);
      end
`ifdef OBSTACLE_SCHEDULER_LANE_GUARD_EN
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (bus.obstacles[i].active && !prev_act[i]) begin
          compare("guard_lane_differs", int'(int'(bus.obstacles[i].lane) != guard_last), 1);
          guard_last = int'(bus.obstacles[i].lane);
        end
        prev_act[i] = bus.obstacles[i].active;
      end
`endif
      prev_busy = bus.busy;
      prev_drop = bus.spawn_dropped;
    end
  end

  // Watchdog: the run must never hang.
  initial begin : watchdog
    repeat (40000) @(posedge system_clock_in);
    $display("[TB] FAIL watchdog: simulation exceeded cycle budget, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus.
  initial begin : stimulus
    int  base;
    int  delta;
    bit  full;
    bus.start = 1'b0;
    bus.game_tick = 1'b0;
    bus.died = 1'b0;
    bus.speed = 4'd0;

    // Reset, then idle with ticks pulsing: nothing may move.
    repeat (3) @(negedge system_clock_in);
    reset_n = 1'b1;
    @(negedge system_clock_in);
    checkOutput("reset", 0, 0, 0, 0);
    compare("reset spawn_dropped", int'(bus.spawn_dropped), 0);
    compare("reset tick_overrun", int'(bus.tick_overrun), 0);
    for (int i = 0; i < 50; i++) begin
      @(negedge system_clock_in);
      bus.game_tick = (i % 5 == 0);
    end
    bus.game_tick = 1'b0;
    @(negedge system_clock_in);
    compare("idle busy_cycles", busy_cycles, 0);
    checkOutput("idle", 0, 0, 0, 0);

    // Run at speed 8: first spawn on tick 5, slot 0 travels 640 -> 0, retires on tick 86.
    doStart();
    bus.speed = 4'd8;
    checkOutput("start1", 0, 0, 0, -1);
    for (int k = 1; k <= 86; k++) begin
      if (k < 5)
        applyStimulus(mk($sformatf("run_t%0d", k), 0, 0, 0, 0, 0, -1, 0), 1'b1, 12);
      else if (k == 5)
        applyStimulus(mk("run_t5", 0, 1, SPAWN_POS, 0, 1, -1, 0), 1'b1, 12);
      else if (k < 86)
        applyStimulus(mk($sformatf("run_t%0d", k), 0, 1, SPAWN_POS - 8 * (k - 5), -1, -1, -1, 0), 1'b1, 12);
      else
        applyStimulus(mk("run_t86", 1, 3, 0, -1, -1, -1, 0), 1'b1, 12);
    end

    // start mid-sweep abandons it and clears everything.
    exp_q.push_back(mk("abandon", 0, 0, 0, 0, 0, -1, 0));
    @(negedge system_clock_in) bus.game_tick = 1'b1;
    @(negedge system_clock_in) bus.game_tick = 1'b0;
    @(negedge system_clock_in);
    @(negedge system_clock_in) bus.start = 1'b1;
    guard_last = 0;
    @(negedge system_clock_in) bus.start = 1'b0;
    repeat (3) @(negedge system_clock_in);
    checkOutput("abandon", 0, 0, 0, -1);

    // Speed 0: fill all ten slots, then every due spawn must be dropped.
    bus.speed = 4'd0;
    for (int k = 1; k <= 4; k++)
      applyStimulus(mk($sformatf("fill_t%0d", k), 0, 0, 0, 0, 0, -1, 0), 1'b1, 12);
    applyStimulus(mk("fill_t5", 0, 1, SPAWN_POS, 0, 1, SPAWN_POS, 0), 1'b1, 12);
    full = 1'b0;
    for (int n = 0; n < 250 && !full; n++) begin
      applyStimulus(mk("fill", 0, 1, SPAWN_POS, 0, -1, SPAWN_POS, 0), 1'b1, 12);
      @(negedge system_clock_in);
      if (seen_active == NUM_SLOTS) full = 1'b1;
    end
    compare("table_filled", int'(full), 1);
    base = drop_seen;
    for (int n = 0; n < 42; n++)
      applyStimulus(mk("full", 0, 1, SPAWN_POS, -1, NUM_SLOTS, SPAWN_POS, 0), 1'b1, 12);
    delta = drop_seen - base;
    compare("drops_in_42_full_ticks_within_2_to_9", int'(delta >= 2 && delta <= 9), 1);

    // Overrun: a second tick 3 cycles into a sweep is discarded.
    doStart();
    bus.speed = 4'd8;
    checkOutput("start3", 0, 0, 0, -1);
    for (int k = 1; k <= 4; k++)
      applyStimulus(mk($sformatf("ovr_t%0d", k), 0, 0, 0, 0, 0, -1, 0), 1'b1, 12);
    applyStimulus(mk("ovr_t5", 0, 1, SPAWN_POS, 0, 1, -1, 0), 1'b1, 12);
    exp_q.push_back(mk("ovr_t6", 0, 1, SPAWN_POS - 8, 0, 1, -1, 1));
    @(negedge system_clock_in) bus.game_tick = 1'b1;
    @(negedge system_clock_in) bus.game_tick = 1'b0;
    @(negedge system_clock_in);
    @(negedge system_clock_in) bus.game_tick = 1'b1;
    @(negedge system_clock_in) bus.game_tick = 1'b0;
    repeat (12) @(negedge system_clock_in);
    applyStimulus(mk("ovr_t7", 0, 1, SPAWN_POS - 16, 0, 1, -1, 1), 1'b1, 12);

    // died rising mid-sweep: that sweep completes, later ticks are ignored.
    exp_q.push_back(mk("died_mid", 0, 1, SPAWN_POS - 24, 0, 1, -1, 1));
    @(negedge system_clock_in) bus.game_tick = 1'b1;
    @(negedge system_clock_in) bus.game_tick = 1'b0;
    @(negedge system_clock_in);
    @(negedge system_clock_in) bus.died = 1'b1;
    repeat (12) @(negedge system_clock_in);
    for (int n = 0; n < 20; n++)
      applyStimulus(mk("ignored", 0, 2, 0, -1, -1, -1, 1), 1'b0, 12);
    checkOutput("frozen", 0, 1, 1, SPAWN_POS - 24);
    compare("frozen tick_overrun_count", overrun_seen, 1);

    // start while dead clears the table and returns to WAIT.
    doStart();
    checkOutput("start4", 0, 0, 0, -1);
    bus.died = 1'b0;
    applyStimulus(mk("after_start", 0, 0, 0, 0, 0, -1, 1), 1'b1, 12);

    compare("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
